// File: rtl/bp_cfg_link_pkg.sv
// Shared definitions for the cfg-link slave: register map constants, FSM states
// and the address decode classes.
package bp_cfg_link_pkg;

  localparam logic [15:0] CFG_ADDR_CLK_OSC  = 16'h0000;
  localparam logic [15:0] CFG_ADDR_RESET    = 16'h0001;
  localparam logic [15:0] CFG_ADDR_FREEZE   = 16'h0002;
  localparam logic [15:0] CFG_ADDR_PC_LO    = 16'h0040;
  localparam logic [15:0] CFG_ADDR_PC_HI    = 16'h0041;
  localparam logic [15:0] CFG_ADDR_CCE_MODE = 16'h0060;
  localparam logic [15:0] CFG_ADDR_UCODE    = 16'h8000;

  typedef enum logic [1:0] {
    e_idle,
    e_ureq,
    e_uresp,
    e_resp
  } bp_cfg_state_e;

  typedef enum logic [2:0] {
    e_dec_clk_osc,
    e_dec_reset,
    e_dec_freeze,
    e_dec_pc_lo,
    e_dec_pc_hi,
    e_dec_cce_mode,
    e_dec_ucode,
    e_dec_unmapped
  } bp_cfg_dec_e;

endpackage

// File: rtl/bp_cfg_addr_decode.sv
// Combinational cfg address decode: classifies an address as a register, a
// ucode entry (with its offset) or unmapped.
module bp_cfg_addr_decode
  import bp_cfg_link_pkg::*;
#(
  parameter int cfg_addr_width_p   = 16,
  parameter int ucode_addr_width_p = 8
) (
  input  logic [cfg_addr_width_p-1:0]   i_addr,
  output bp_cfg_dec_e                   o_class,
  output logic [ucode_addr_width_p-1:0] o_ucode_off
);

  logic [cfg_addr_width_p-1:0] w_uoff;
  logic                        w_ucode_hit;

  // A ucode hit needs the address at or above the window base and every offset
  // bit above the entry index clear; anything past the window is unmapped.
  assign w_uoff      = i_addr - cfg_addr_width_p'(CFG_ADDR_UCODE);
  assign w_ucode_hit = (i_addr >= cfg_addr_width_p'(CFG_ADDR_UCODE))
                    && (w_uoff[cfg_addr_width_p-1:ucode_addr_width_p] == '0);
  assign o_ucode_off = w_uoff[ucode_addr_width_p-1:0];

  always_comb begin
    o_class = e_dec_unmapped;
    if (w_ucode_hit) begin
      o_class = e_dec_ucode;
    end else begin
      case (i_addr)
        cfg_addr_width_p'(CFG_ADDR_CLK_OSC):  o_class = e_dec_clk_osc;
        cfg_addr_width_p'(CFG_ADDR_RESET):    o_class = e_dec_reset;
        cfg_addr_width_p'(CFG_ADDR_FREEZE):   o_class = e_dec_freeze;
        cfg_addr_width_p'(CFG_ADDR_PC_LO):    o_class = e_dec_pc_lo;
        cfg_addr_width_p'(CFG_ADDR_PC_HI):    o_class = e_dec_pc_hi;
        cfg_addr_width_p'(CFG_ADDR_CCE_MODE): o_class = e_dec_cce_mode;
        default:                              o_class = e_dec_unmapped;
      endcase
    end
  end

endmodule

// File: rtl/bp_cfg_node.sv
// Config-link slave for a tile: per-core reset/freeze, boot PC and CCE mode
// registers with read-back, plus a handshaked forwarding port for CCE ucode.
module bp_cfg_node
  import bp_cfg_link_pkg::*;
#(
  parameter int num_core_p         = 1,
  parameter int vaddr_width_p      = 39,
  parameter int cfg_addr_width_p   = 16,
  parameter int cfg_data_width_p   = 32,
  parameter int ucode_addr_width_p = 8,
  parameter int ucode_data_width_p = 32,
  parameter int cce_mode_width_p   = 1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          cfg_v_i,
  input  logic                          cfg_w_i,
  input  logic [cfg_addr_width_p-1:0]   cfg_addr_i,
  input  logic [cfg_data_width_p-1:0]   cfg_data_i,
  output logic                          cfg_ready_o,
  output logic                          cfg_v_o,
  output logic [cfg_data_width_p-1:0]   cfg_data_o,
  input  logic                          cfg_ready_i,
  output logic [num_core_p-1:0]         core_reset_o,
  output logic [num_core_p-1:0]         freeze_o,
  output logic [vaddr_width_p-1:0]      start_pc_o,
  output logic [cce_mode_width_p-1:0]   cce_mode_o,
  output logic                          ucode_v_o,
  output logic                          ucode_w_o,
  output logic [ucode_addr_width_p-1:0] ucode_addr_o,
  output logic [ucode_data_width_p-1:0] ucode_data_o,
  input  logic                          ucode_ready_i,
  input  logic                          ucode_v_i,
  input  logic [ucode_data_width_p-1:0] ucode_data_i
);

  bp_cfg_state_e                 r_state;
  logic [cfg_data_width_p-1:0]   r_clk_osc;
  logic [num_core_p-1:0]         r_core_reset;
  logic [num_core_p-1:0]         r_freeze;
  logic [vaddr_width_p-1:0]      r_start_pc;
  logic [cce_mode_width_p-1:0]   r_cce_mode;
  logic                          r_cfg_ready;
  logic                          r_cfg_v;
  logic [cfg_data_width_p-1:0]   r_cfg_data;
  logic                          r_ucode_v;
  logic                          r_ucode_w;
  logic [ucode_addr_width_p-1:0] r_ucode_addr;
  logic [ucode_data_width_p-1:0] r_ucode_data;

  bp_cfg_dec_e                   w_class;
  logic [ucode_addr_width_p-1:0] w_uoff;
  logic [cfg_data_width_p-1:0]   w_rd_data;

  bp_cfg_addr_decode #(
    .cfg_addr_width_p  (cfg_addr_width_p),
    .ucode_addr_width_p(ucode_addr_width_p)
  ) u_decode (
    .i_addr     (cfg_addr_i),
    .o_class    (w_class),
    .o_ucode_off(w_uoff)
  );

  // Register read-back, zero-extended to the link width; unmapped reads give 0.
  always_comb begin
    w_rd_data = '0;
    case (w_class)
      e_dec_clk_osc:  w_rd_data = r_clk_osc;
      e_dec_reset:    w_rd_data = cfg_data_width_p'(r_core_reset);
      e_dec_freeze:   w_rd_data = cfg_data_width_p'(r_freeze);
      e_dec_pc_lo:    w_rd_data = cfg_data_width_p'(r_start_pc[31:0]);
      e_dec_pc_hi:    w_rd_data = cfg_data_width_p'(r_start_pc[vaddr_width_p-1:32]);
      e_dec_cce_mode: w_rd_data = cfg_data_width_p'(r_cce_mode);
      default:        w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= e_idle;
      r_clk_osc    <= '0;
      r_core_reset <= '1;
      r_freeze     <= '1;
      r_start_pc   <= '0;
      r_cce_mode   <= '0;
      r_cfg_ready  <= 1'b1;
      r_cfg_v      <= 1'b0;
      r_cfg_data   <= '0;
      r_ucode_v    <= 1'b0;
      r_ucode_w    <= 1'b0;
      r_ucode_addr <= '0;
      r_ucode_data <= '0;
    end else begin
      case (r_state)
        e_idle: begin
          if (cfg_v_i) begin
            if (w_class == e_dec_ucode) begin
              r_state      <= e_ureq;
              r_cfg_ready  <= 1'b0;
              r_ucode_v    <= 1'b1;
              r_ucode_w    <= cfg_w_i;
              r_ucode_addr <= w_uoff;
              r_ucode_data <= cfg_data_i[ucode_data_width_p-1:0];
            end else if (cfg_w_i) begin
              case (w_class)
                e_dec_clk_osc:  r_clk_osc    <= cfg_data_i;
                e_dec_reset:    r_core_reset <= cfg_data_i[num_core_p-1:0];
                e_dec_freeze:   r_freeze     <= cfg_data_i[num_core_p-1:0];
                e_dec_pc_lo:    r_start_pc[31:0] <= cfg_data_i[31:0];
                e_dec_pc_hi:    r_start_pc[vaddr_width_p-1:32] <= cfg_data_i[vaddr_width_p-33:0];
                e_dec_cce_mode: r_cce_mode   <= cfg_data_i[cce_mode_width_p-1:0];
                default:        ;
              endcase
            end else begin
              r_state     <= e_resp;
              r_cfg_ready <= 1'b0;
              r_cfg_v     <= 1'b1;
              r_cfg_data  <= w_rd_data;
            end
          end
        end
        e_ureq: begin
          if (ucode_ready_i) begin
            r_ucode_v <= 1'b0;
            if (r_ucode_w) begin
              r_state     <= e_idle;
              r_cfg_ready <= 1'b1;
            end else begin
              r_state <= e_uresp;
            end
          end
        end
        e_uresp: begin
          if (ucode_v_i) begin
            r_state    <= e_resp;
            r_cfg_v    <= 1'b1;
            r_cfg_data <= cfg_data_width_p'(ucode_data_i);
          end
        end
        e_resp: begin
          if (cfg_ready_i) begin
            r_state     <= e_idle;
            r_cfg_v     <= 1'b0;
            r_cfg_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= e_idle;
          r_cfg_ready <= 1'b1;
          r_cfg_v     <= 1'b0;
          r_ucode_v   <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready_o  = r_cfg_ready;
  assign cfg_v_o      = r_cfg_v;
  assign cfg_data_o   = r_cfg_data;
  assign core_reset_o = r_core_reset;
  assign freeze_o     = r_freeze;
  assign start_pc_o   = r_start_pc;
  assign cce_mode_o   = r_cce_mode;
  assign ucode_v_o    = r_ucode_v;
  assign ucode_w_o    = r_ucode_w;
  assign ucode_addr_o = r_ucode_addr;
  assign ucode_data_o = r_ucode_data;

endmodule

// File: tb/tb_bp_cfg_node.sv
// Scoreboard bench for bp_cfg_node with four cores: directed cfg traffic with
// expected read data queued at issue and checked by an independent monitor.
module tb_bp_cfg_node;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        cfg_v_i;
  logic        cfg_w_i;
  logic [15:0] cfg_addr_i;
  logic [31:0] cfg_data_i;
  logic        cfg_ready_o;
  logic        cfg_v_o;
  logic [31:0] cfg_data_o;
  logic        cfg_ready_i;
  logic [3:0]  core_reset_o;
  logic [3:0]  freeze_o;
  logic [38:0] start_pc_o;
  logic [0:0]  cce_mode_o;
  logic        ucode_v_o;
  logic        ucode_w_o;
  logic [7:0]  ucode_addr_o;
  logic [31:0] ucode_data_o;
  logic        ucode_ready_i;
  logic        ucode_v_i;
  logic [31:0] ucode_data_i;

  int          nCompared = 0;
  int          nFail     = 0;
  logic [31:0] expQ[$];

  always #5 clk_i = ~clk_i;

  bp_cfg_node #(
    .num_core_p(4)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .cfg_v_i      (cfg_v_i),
    .cfg_w_i      (cfg_w_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_data_i   (cfg_data_i),
    .cfg_ready_o  (cfg_ready_o),
    .cfg_v_o      (cfg_v_o),
    .cfg_data_o   (cfg_data_o),
    .cfg_ready_i  (cfg_ready_i),
    .core_reset_o (core_reset_o),
    .freeze_o     (freeze_o),
    .start_pc_o   (start_pc_o),
    .cce_mode_o   (cce_mode_o),
    .ucode_v_o    (ucode_v_o),
    .ucode_w_o    (ucode_w_o),
    .ucode_addr_o (ucode_addr_o),
    .ucode_data_o (ucode_data_o),
    .ucode_ready_i(ucode_ready_i),
    .ucode_v_i    (ucode_v_i),
    .ucode_data_i (ucode_data_i)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request; reads push their expected data for the monitor. With
  // chkLat set, the response must be valid the cycle after acceptance.
  task automatic applyStimulus(input logic w, input logic [15:0] addr, input logic [31:0] data,
                               input logic [31:0] expRd, input logic chkLat);
    int n = 0;
    if (!w) expQ.push_back(expRd);
    @(posedge clk_i); #1;
    cfg_v_i    = 1'b1;
    cfg_w_i    = w;
    cfg_addr_i = addr;
    cfg_data_i = data;
    forever begin
      @(negedge clk_i);
      if (cfg_ready_o) break;
      n++;
      if (n > 50) begin
        nCompared++;
        nFail++;
        $display("[TB] FAIL accept_timeout: addr 0x%0h never accepted, required cfg_ready_o=1", addr);
        break;
      end
    end
    @(posedge clk_i); #1;
    cfg_v_i = 1'b0;
    if (chkLat) begin
      @(negedge clk_i);
      checkOutput("rd_latency_v", cfg_v_o, 1);
      checkOutput("rd_no_ucode", ucode_v_o, 0);
    end
  endtask

  // Monitor: every consumed response is matched against the oldest expectation.
  always @(negedge clk_i) begin
    if (cfg_v_o && cfg_ready_i) begin
      if (expQ.size() == 0) begin
        nCompared++;
        nFail++;
        $display("[TB] FAIL unexpected_resp: got 0x%0h, expected no response", cfg_data_o);
      end else begin
        checkOutput("rd_data", cfg_data_o, expQ.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_i       = 1'b1;
    cfg_v_i       = 1'b0;
    cfg_w_i       = 1'b0;
    cfg_addr_i    = '0;
    cfg_data_i    = '0;
    cfg_ready_i   = 1'b1;
    ucode_ready_i = 1'b0;
    ucode_v_i     = 1'b0;
    ucode_data_i  = '0;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;

    @(negedge clk_i);
    checkOutput("rst_core_reset", core_reset_o, 4'hf);
    checkOutput("rst_freeze", freeze_o, 4'hf);
    checkOutput("rst_start_pc", start_pc_o, 0);
    checkOutput("rst_cce_mode", cce_mode_o, 0);
    checkOutput("rst_cfg_ready", cfg_ready_o, 1);
    checkOutput("rst_cfg_v", cfg_v_o, 0);
    checkOutput("rst_ucode_v", ucode_v_o, 0);

    // Boot PC split across two registers, read back with zero-extension.
    applyStimulus(1, 16'h0040, 32'h8000_0000, 0, 0);
    applyStimulus(1, 16'h0041, 32'h0000_01ff, 0, 0);
    @(negedge clk_i);
    checkOutput("start_pc", start_pc_o, 39'h7f_8000_0000);
    applyStimulus(0, 16'h0040, 0, 32'h8000_0000, 1);
    applyStimulus(0, 16'h0041, 0, 32'h0000_007f, 1);

    // Freeze uses only the low core bits.
    applyStimulus(1, 16'h0002, 32'hffff_fff5, 0, 0);
    @(negedge clk_i);
    checkOutput("freeze_wr", freeze_o, 4'h5);
    applyStimulus(0, 16'h0002, 0, 32'h5, 1);

    applyStimulus(1, 16'h0001, 32'h1234_567a, 0, 0);
    @(negedge clk_i);
    checkOutput("core_reset_wr", core_reset_o, 4'ha);
    applyStimulus(0, 16'h0001, 0, 32'ha, 1);
    applyStimulus(1, 16'h0000, 32'h1234_5678, 0, 0);
    applyStimulus(0, 16'h0000, 0, 32'h1234_5678, 1);
    applyStimulus(1, 16'h0060, 32'hffff_ffff, 0, 0);
    @(negedge clk_i);
    checkOutput("cce_mode_wr", cce_mode_o, 1);
    applyStimulus(0, 16'h0060, 0, 32'h1, 1);

    // Stray ucode data while idle must not produce a response.
    @(posedge clk_i); #1;
    ucode_v_i    = 1'b1;
    ucode_data_i = 32'h0bad_0bad;
    @(posedge clk_i); #1;
    ucode_v_i = 1'b0;
    @(negedge clk_i);
    checkOutput("stray_ucode_v", cfg_v_o, 0);

    // Ucode write stalled three cycles by the slave.
    applyStimulus(1, 16'h8003, 32'hdead_beef, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checkOutput("uwr_v_held", ucode_v_o, 1);
      checkOutput("uwr_addr", ucode_addr_o, 8'h03);
      checkOutput("uwr_w", ucode_w_o, 1);
      checkOutput("uwr_data", ucode_data_o, 32'hdead_beef);
      checkOutput("uwr_cfg_ready", cfg_ready_o, 0);
      @(posedge clk_i); #1;
    end
    ucode_ready_i = 1'b1;
    @(negedge clk_i);
    checkOutput("uwr_v_4th", ucode_v_o, 1);
    @(posedge clk_i); #1;
    ucode_ready_i = 1'b0;
    @(negedge clk_i);
    checkOutput("uwr_done_ready", cfg_ready_o, 1);
    checkOutput("uwr_done_v", ucode_v_o, 0);

    // Ucode read: data returns after two cycles, then the link stalls the response.
    cfg_ready_i   = 1'b0;
    ucode_ready_i = 1'b1;
    applyStimulus(0, 16'h8003, 0, 32'hdead_beef, 0);
    @(negedge clk_i);
    checkOutput("urd_v", ucode_v_o, 1);
    checkOutput("urd_w", ucode_w_o, 0);
    checkOutput("urd_addr", ucode_addr_o, 8'h03);
    @(posedge clk_i); #1;
    ucode_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    ucode_v_i    = 1'b1;
    ucode_data_i = 32'hdead_beef;
    @(posedge clk_i); #1;
    ucode_v_i    = 1'b0;
    ucode_data_i = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      checkOutput("urd_resp_held_v", cfg_v_o, 1);
      checkOutput("urd_resp_held_d", cfg_data_o, 32'hdead_beef);
      @(posedge clk_i); #1;
    end
    cfg_ready_i = 1'b1;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checkOutput("urd_consumed", cfg_v_o, 0);

    // Unmapped space: reads give zero with no ucode traffic, writes vanish.
    applyStimulus(0, 16'h0090, 0, 32'h0, 1);
    applyStimulus(0, 16'h8100, 0, 32'h0, 1);
    applyStimulus(1, 16'h8100, 32'h5555_5555, 0, 0);
    @(negedge clk_i);
    checkOutput("unmapped_wr_no_ucode", ucode_v_o, 0);
    checkOutput("unmapped_wr_ready", cfg_ready_o, 1);

    // Asynchronous reset in the middle of a stalled ucode request.
    applyStimulus(1, 16'h8005, 32'h0000_0001, 0, 0);
    @(negedge clk_i);
    checkOutput("pre_rst_ucode_v", ucode_v_o, 1);
    #2 reset_i = 1'b1;
    #1;
    checkOutput("async_rst_ucode_v", ucode_v_o, 0);
    checkOutput("async_rst_ready", cfg_ready_o, 1);
    checkOutput("async_rst_pc", start_pc_o, 0);
    checkOutput("async_rst_freeze", freeze_o, 4'hf);
    checkOutput("async_rst_core_reset", core_reset_o, 4'hf);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    applyStimulus(0, 16'h0040, 0, 32'h0, 1);
    applyStimulus(0, 16'h0000, 0, 32'h0, 1);

    repeat (3) @(posedge clk_i);
    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
    $finish;
  end

endmodule
